// File: rtl/arm_isa_pkg.sv
// ARM instruction-set constants, opcode enum and field payload shared by the encoder.
package arm_isa_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned COND_MSB = 31;
  localparam int unsigned COND_LSB = 28;

  typedef enum logic [OP_W-1:0] {
    OP_LDR = 5'd0,
    OP_STR,
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN,
    OP_B,
    OP_BL,
    OP_MUL,
    OP_MLA,
    OP_SWP,
    OP_SWI
  } op_t;

  typedef logic [3:0] dp_opcode_t;
  localparam dp_opcode_t DP_AND = 4'd0;
  localparam dp_opcode_t DP_EOR = 4'd1;
  localparam dp_opcode_t DP_SUB = 4'd2;
  localparam dp_opcode_t DP_RSB = 4'd3;
  localparam dp_opcode_t DP_ADD = 4'd4;
  localparam dp_opcode_t DP_ADC = 4'd5;
  localparam dp_opcode_t DP_SBC = 4'd6;
  localparam dp_opcode_t DP_RSC = 4'd7;
  localparam dp_opcode_t DP_TST = 4'd8;
  localparam dp_opcode_t DP_TEQ = 4'd9;
  localparam dp_opcode_t DP_CMP = 4'd10;
  localparam dp_opcode_t DP_CMN = 4'd11;
  localparam dp_opcode_t DP_ORR = 4'd12;
  localparam dp_opcode_t DP_MOV = 4'd13;
  localparam dp_opcode_t DP_BIC = 4'd14;
  localparam dp_opcode_t DP_MVN = 4'd15;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [3:0] MUL_SWP_SIG = 4'b1001;
  localparam logic [3:0] COND_NV     = 4'hF;
  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  // Decoded-field payload handed from the handshake stage to the packer.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [3:0]       cond;
    logic             set;
    logic             byte_sel;
    logic             immediate;
    logic             pre_index;
    logic             up;
    logic             writeback;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [REG_W-1:0] rs;
    logic [4:0]       shift_amt;
    logic [1:0]       shift_type;
    logic [11:0]      imm12;
    logic [23:0]      imm24;
  } instr_fields_t;

  // Data-processing ops are contiguous in op_t, in ARM opcode order.
  function automatic dp_opcode_t dp_opcode(input logic [OP_W-1:0] op);
    return 4'(op - OP_AND);
  endfunction

endpackage

// File: rtl/iencoder_pack.sv
// Combinational ARM field packer with legality check.
// IENC_MUL_SWP_EN enables MUL/MLA/SWP; otherwise those ops are flagged illegal.
module iencoder_pack
  import arm_isa_pkg::*;
(
  input  instr_fields_t      fields,
  output logic [WORD_W-1:0]  word_c,
  output logic               illegal_c
);

  logic [COND_LSB-1:0] body;
  logic [11:0]         op2;
  dp_opcode_t          opc;
  logic                dp_test;
  logic                dp_move;
  logic                mul_illegal;
  logic                swp_illegal;

  always_comb begin
    op2 = fields.immediate ? fields.imm12
                           : {fields.shift_amt, fields.shift_type, 1'b0, fields.rm};
    opc = dp_opcode(fields.op);
    dp_test = (opc == DP_TST) || (opc == DP_TEQ) || (opc == DP_CMP) || (opc == DP_CMN);
    dp_move = (opc == DP_MOV) || (opc == DP_MVN);
`ifdef IENC_MUL_SWP_EN
    mul_illegal = (fields.rd == fields.rm) || (fields.rd == REG_PC);
    swp_illegal = 1'b0;
`else
    mul_illegal = 1'b1;
    swp_illegal = 1'b1;
`endif
  end

  // Body bits [27:0] per instruction class; cond always sits on top.
  always_comb begin
    body      = '0;
    illegal_c = (fields.cond == COND_NV);
    case (fields.op)
      OP_LDR, OP_STR:
        body = {2'b01, ~fields.immediate, fields.pre_index, fields.up, fields.byte_sel,
                fields.pre_index & fields.writeback, fields.op == OP_LDR,
                fields.rn, fields.rd, op2};
      OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
      OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN:
        body = {2'b00, fields.immediate, opc, fields.set | dp_test,
                dp_move ? 4'd0 : fields.rn, dp_test ? 4'd0 : fields.rd, op2};
      OP_B, OP_BL:
        body = {3'b101, fields.op == OP_BL, fields.imm24};
      OP_MUL, OP_MLA: begin
        body = {6'b000000, fields.op == OP_MLA, fields.set, fields.rd,
                (fields.op == OP_MLA) ? fields.rn : 4'd0, fields.rs, MUL_SWP_SIG, fields.rm};
        illegal_c = illegal_c | mul_illegal;
      end
      OP_SWP: begin
        body = {5'b00010, fields.byte_sel, 2'b00, fields.rn, fields.rd, 4'b0000,
                MUL_SWP_SIG, fields.rm};
        illegal_c = illegal_c | swp_illegal;
      end
      OP_SWI:
        body = {4'hF, fields.imm24};
      default:
        illegal_c = 1'b1;
    endcase
  end

  always_comb begin
    word_c = '0;
    word_c[COND_MSB:COND_LSB] = fields.cond;
    word_c[COND_LSB-1:0]      = body;
  end

endmodule

// File: rtl/iencoder.sv
// ARM instruction encoder: handshake, one-deep write register and wrapping address counter.
// IENC_MUL_SWP_EN (see iencoder_pack) selects MUL/MLA/SWP support.
module iencoder
  import arm_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OP_W-1:0]   i_op,
  input  logic [3:0]        i_cond,
  input  logic              i_set,
  input  logic              i_byte,
  input  logic              i_immediate,
  input  logic              i_pre_index,
  input  logic              i_up,
  input  logic              i_writeback,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [REG_W-1:0]  i_rn,
  input  logic [REG_W-1:0]  i_rm,
  input  logic [REG_W-1:0]  i_rs,
  input  logic [4:0]        i_shift_amt,
  input  logic [1:0]        i_shift_type,
  input  logic [11:0]       i_imm12,
  input  logic [23:0]       i_imm24,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  output logic [31:0]       o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic              o_err,
  output logic              o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  instr_fields_t     fields;
  logic [WORD_W-1:0] word_c;
  logic              illegal_c;
  logic              drain_c;
  logic              accept_c;
  logic [AW-1:0]     word_idx;

  always_comb begin
    fields            = '0;
    fields.op         = i_op;
    fields.cond       = i_cond;
    fields.set        = i_set;
    fields.byte_sel   = i_byte;
    fields.immediate  = i_immediate;
    fields.pre_index  = i_pre_index;
    fields.up         = i_up;
    fields.writeback  = i_writeback;
    fields.rd         = i_rd;
    fields.rn         = i_rn;
    fields.rm         = i_rm;
    fields.rs         = i_rs;
    fields.shift_amt  = i_shift_amt;
    fields.shift_type = i_shift_type;
    fields.imm12      = i_imm12;
    fields.imm24      = i_imm24;
  end

  iencoder_pack u_pack (
    .fields    (fields),
    .word_c    (word_c),
    .illegal_c (illegal_c)
  );

  // The pending slot frees up in the same cycle memory takes the held word.
  always_comb begin
    drain_c  = o_mem_we && i_mem_ready;
    o_ready  = !o_full && (!o_mem_we || i_mem_ready);
    accept_c = i_valid && o_ready && !i_clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= BASE_ADDR;
      o_mem_wdata <= '0;
      o_err       <= 1'b0;
      o_full      <= 1'b0;
      word_idx    <= '0;
    end else if (i_clear) begin
      o_mem_we    <= 1'b0;
      o_mem_addr  <= BASE_ADDR;
      o_err       <= 1'b0;
      o_full      <= 1'b0;
      word_idx    <= '0;
    end else begin
      o_err <= accept_c && illegal_c;
      // o_mem_addr always names the slot the held (or next) word goes to.
      if (drain_c) begin
        if (word_idx == LAST_IDX) begin
          word_idx   <= '0;
          o_mem_addr <= BASE_ADDR;
          o_full     <= 1'b1;
        end else begin
          word_idx   <= word_idx + AW'(1);
          o_mem_addr <= o_mem_addr + 32'd4;
        end
      end
      if (accept_c && !illegal_c) begin
        o_mem_we    <= 1'b1;
        o_mem_wdata <= word_c;
      end else if (drain_c) begin
        o_mem_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iencoder.sv
// Self-checking bench for iencoder: directed vectors plus randomized stream vs. a reference model.
module tb_iencoder;
  import arm_isa_pkg::*;

  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int unsigned DEPTH_T = 64;

  typedef struct {
    int unsigned op, cond, rd, rn, rm, rs, shamt, stype, imm12, imm24;
    int unsigned s, b, i, p, u, w;
  } fld_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_clear = 1'b0, i_valid = 1'b0, i_mem_ready = 1'b1;
  logic [4:0]  i_op = '0;
  logic [3:0]  i_cond = '0;
  logic        i_set = 1'b0, i_byte = 1'b0, i_immediate = 1'b0;
  logic        i_pre_index = 1'b0, i_up = 1'b0, i_writeback = 1'b0;
  logic [3:0]  i_rd = '0, i_rn = '0, i_rm = '0, i_rs = '0;
  logic [4:0]  i_shift_amt = '0;
  logic [1:0]  i_shift_type = '0;
  logic [11:0] i_imm12 = '0;
  logic [23:0] i_imm24 = '0;
  logic        o_ready, o_mem_we, o_err, o_full;
  logic [31:0] o_mem_addr, o_mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_pend = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_data = '0;
  int unsigned m_wr = 0;
  int unsigned m_total = 0;
  int unsigned mon_writes = 0;

  always #5 clk = ~clk;

  iencoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH_T)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_cond(i_cond), .i_set(i_set), .i_byte(i_byte),
    .i_immediate(i_immediate), .i_pre_index(i_pre_index), .i_up(i_up),
    .i_writeback(i_writeback), .i_rd(i_rd), .i_rn(i_rn), .i_rm(i_rm), .i_rs(i_rs),
    .i_shift_amt(i_shift_amt), .i_shift_type(i_shift_type), .i_imm12(i_imm12),
    .i_imm24(i_imm24), .o_mem_we(o_mem_we), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_err(o_err), .o_full(o_full)
  );

  always @(posedge clk)
    if (rst_n && o_mem_we && i_mem_ready && !i_clear) mon_writes++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic fld_t blank(input int unsigned op, input int unsigned cond);
    fld_t f;
    f = '{default: 0};
    f.op = op;
    f.cond = cond;
    return f;
  endfunction

  function automatic fld_t rand_fld();
    fld_t f;
    f.op    = ($urandom_range(0, 7) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 23);
    f.cond  = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 14);
    f.rd    = $urandom_range(0, 15);
    f.rn    = $urandom_range(0, 15);
    f.rm    = $urandom_range(0, 15);
    f.rs    = $urandom_range(0, 15);
    f.shamt = $urandom_range(0, 31);
    f.stype = $urandom_range(0, 3);
    f.imm12 = $urandom_range(0, 4095);
    f.imm24 = $urandom_range(0, 24'hFFFFFF);
    f.s = $urandom_range(0, 1); f.b = $urandom_range(0, 1); f.i = $urandom_range(0, 1);
    f.p = $urandom_range(0, 1); f.u = $urandom_range(0, 1); f.w = $urandom_range(0, 1);
    return f;
  endfunction

  function automatic fld_t swi_fld();
    fld_t f;
    f = blank(OP_SWI, 14);
    f.imm24 = $urandom_range(0, 24'hFFFFFF);
    return f;
  endfunction

  // Encoding built straight from the ARM field layout with shifts and ORs.
  function automatic void model_encode(input fld_t f, output logic [31:0] w, output bit bad);
    int unsigned op2, c, opc, rd, rn, s, v;
    op2 = (f.i != 0) ? f.imm12 : (f.shamt << 7) + (f.stype << 5) + f.rm;
    c   = f.cond << 28;
    bad = (f.cond == 15) || (f.op > 23);
    v   = 0;
    if (f.op == OP_LDR || f.op == OP_STR) begin
      v = c | (1 << 26) | ((1 - f.i) << 25) | (f.p << 24) | (f.u << 23) | (f.b << 22)
          | ((f.p & f.w) << 21) | ((f.op == OP_LDR ? 1 : 0) << 20)
          | (f.rn << 16) | (f.rd << 12) | op2;
    end else if (f.op >= OP_AND && f.op <= OP_MVN) begin
      opc = f.op - OP_AND; rd = f.rd; rn = f.rn; s = f.s;
      if (opc >= 8 && opc <= 11) begin s = 1; rd = 0; end
      if (opc == 13 || opc == 15) rn = 0;
      v = c | (f.i << 25) | (opc << 21) | (s << 20) | (rn << 16) | (rd << 12) | op2;
    end else if (f.op == OP_B || f.op == OP_BL) begin
      v = c | (5 << 25) | ((f.op == OP_BL ? 1 : 0) << 24) | f.imm24;
    end else if (f.op == OP_MUL || f.op == OP_MLA) begin
`ifdef IENC_MUL_SWP_EN
      if (f.rd == f.rm || f.rd == 15) bad = 1;
      v = c | ((f.op == OP_MLA ? 1 : 0) << 21) | (f.s << 20) | (f.rd << 16)
          | ((f.op == OP_MLA ? f.rn : 0) << 12) | (f.rs << 8) | (9 << 4) | f.rm;
`else
      bad = 1;
`endif
    end else if (f.op == OP_SWP) begin
`ifdef IENC_MUL_SWP_EN
      v = c | (1 << 24) | (f.b << 22) | (f.rn << 16) | (f.rd << 12) | (9 << 4) | f.rm;
`else
      bad = 1;
`endif
    end else if (f.op == OP_SWI) begin
      v = c | (15 << 24) | f.imm24;
    end
    w = 32'(v);
  endfunction

  task automatic drive(input bit v, input fld_t f, input bit mr, input bit clr);
    i_valid = v; i_mem_ready = mr; i_clear = clr;
    i_op = 5'(f.op); i_cond = 4'(f.cond);
    i_set = 1'(f.s); i_byte = 1'(f.b); i_immediate = 1'(f.i);
    i_pre_index = 1'(f.p); i_up = 1'(f.u); i_writeback = 1'(f.w);
    i_rd = 4'(f.rd); i_rn = 4'(f.rn); i_rm = 4'(f.rm); i_rs = 4'(f.rs);
    i_shift_amt = 5'(f.shamt); i_shift_type = 2'(f.stype);
    i_imm12 = 12'(f.imm12); i_imm24 = 24'(f.imm24);
  endtask

  task automatic compare_outputs();
    check("mem_we", 32'(o_mem_we), 32'(m_pend));
    check("mem_addr", o_mem_addr, BASE + 32'(4 * (m_wr % DEPTH_T)));
    if (m_pend) check("mem_wdata", o_mem_wdata, m_data);
    check("err", 32'(o_err), 32'(m_err));
    check("full", 32'(o_full), 32'(m_wr >= DEPTH_T));
  endtask

  // One clock: drive at the falling edge, predict, compare after the next falling edge.
  task automatic step(input bit v, input fld_t f, input bit mr, input bit clr);
    logic [31:0] w;
    bit bad, exp_ready, drain, acc;
    drive(v, f, mr, clr);
    #1;
    exp_ready = (m_wr < DEPTH_T) && (!m_pend || mr);
    check("ready", 32'(o_ready), 32'(exp_ready));
    model_encode(f, w, bad);
    drain = m_pend && mr;
    acc   = v && exp_ready && !clr;
    @(posedge clk);
    if (clr) begin
      m_pend = 0; m_wr = 0; m_err = 0;
    end else begin
      if (drain) begin m_wr++; m_total++; end
      m_err = acc && bad;
      if (acc && !bad) begin m_pend = 1; m_data = w; end
      else if (drain) m_pend = 0;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    fld_t f;
    fld_t idle;
    idle = blank(OP_SWI, 14);

    // reset values
    drive(0, idle, 1, 0);
    repeat (2) @(negedge clk);
    check("rst_we", 32'(o_mem_we), 32'd0);
    check("rst_addr", o_mem_addr, BASE);
    check("rst_wdata", o_mem_wdata, 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    compare_outputs();

    // directed encodings
    f = blank(OP_ADD, 14); f.s = 1; f.rd = 1; f.rn = 2; f.i = 1; f.imm12 = 5;
    step(1, f, 1, 0);
    check("add_addr", o_mem_addr, 32'h0);
    check("add_data", o_mem_wdata, 32'hE2921005);
    f = blank(OP_MOV, 14); f.rd = 3; f.rm = 4; f.shamt = 2; f.stype = 32'(SHIFT_LSL);
    f.rn = 9;
    step(1, f, 1, 0);
    check("mov_addr", o_mem_addr, 32'h4);
    check("mov_data", o_mem_wdata, 32'hE1A03104);
    f = blank(OP_CMP, 14); f.rn = 1; f.i = 1; f.rd = 7;
    step(1, f, 1, 0);
    check("cmp_data", o_mem_wdata, 32'hE3510000);
    step(0, idle, 1, 1);
    check("clr_addr", o_mem_addr, BASE);
    f = blank(OP_LDR, 14); f.p = 1; f.u = 1; f.rn = 1; f.i = 1; f.imm12 = 4;
    step(1, f, 1, 0);
    check("ldr_addr", o_mem_addr, 32'h0);
    check("ldr_data", o_mem_wdata, 32'hE5910004);
    f = blank(OP_BL, 14); f.imm24 = 32'h10;
    step(1, f, 1, 0);
    check("bl_addr", o_mem_addr, 32'h4);
    check("bl_data", o_mem_wdata, 32'hEB000010);
    step(0, idle, 1, 0);

    // stall for three cycles with the source still offering words
    step(1, swi_fld(), 1, 0);
    repeat (3) step(1, swi_fld(), 0, 0);
    repeat (3) step(1, swi_fld(), 1, 0);
    step(0, idle, 1, 0);

    // illegal: cond NV, then MUL/MLA handling
    step(0, idle, 1, 1);
    f = blank(OP_ADD, 15);
    step(1, f, 1, 0);
    check("nv_err", 32'(o_err), 32'd1);
    check("nv_we", 32'(o_mem_we), 32'd0);
    step(0, idle, 1, 0);
    check("nv_err_once", 32'(o_err), 32'd0);
`ifdef IENC_MUL_SWP_EN
    f = blank(OP_MUL, 14); f.rd = 2; f.rm = 2; f.rs = 3;
    step(1, f, 1, 0);
    check("mul_rdrm_err", 32'(o_err), 32'd1);
    f = blank(OP_MUL, 14); f.rd = 1; f.rm = 2; f.rs = 3; f.rn = 5;
    step(1, f, 1, 0);
    check("mul_data", o_mem_wdata, 32'hE0010392);
`else
    f = blank(OP_MLA, 14); f.rd = 1; f.rm = 2; f.rs = 3;
    step(1, f, 1, 0);
    check("mla_err", 32'(o_err), 32'd1);
`endif
    step(0, idle, 1, 0);

    // fill the whole memory, wrap, full, then clear
    step(0, idle, 1, 1);
    for (int k = 0; k < DEPTH_T; k++) step(1, swi_fld(), 1, 0);
    check("last_addr", o_mem_addr, BASE + 32'(4 * (DEPTH_T - 1)));
    step(0, idle, 1, 0);
    check("full_set", 32'(o_full), 32'd1);
    check("full_ready", 32'(o_ready), 32'd0);
    check("wrap_addr", o_mem_addr, BASE);
    step(1, swi_fld(), 1, 0);
    step(0, idle, 1, 1);
    check("clr_full", 32'(o_full), 32'd0);
    check("clr_wrap_addr", o_mem_addr, BASE);

    // reset in the middle of a stalled write
    step(1, swi_fld(), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(o_mem_we), 32'd0);
    check("arst_addr", o_mem_addr, BASE);
    check("arst_wdata", o_mem_wdata, 32'd0);
    m_pend = 0; m_wr = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized stream
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 7, rand_fld(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0);
    step(0, idle, 1, 0);
    step(0, idle, 1, 0);
    check("write_count", 32'(mon_writes), 32'(m_total));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
